// File: rtl/exception_unit.sv
// Exception back end: captures exception state, steers the PC mux to the handler
// vector or back to ELR, and runs the external interrupt synchronise/mask/ack path.
module exception_unit #(
  parameter int             N      = 64,
  parameter logic [N-1:0]   VECTOR = 64'hD8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         Exc,
  input  logic         ERet,
  input  logic [3:0]   EStatus,
  input  logic [N-1:0] PC_cur,
  input  logic [31:0]  Instr,
  input  logic         IrqReq,
  input  logic [1:0]   SysSel,
  output logic         ExtIRQ,
  output logic         IrqAck,
  output logic         EProc,
  output logic         ERetSel,
  output logic [N-1:0] Vector,
  output logic [N-1:0] ELR,
  output logic [N-1:0] SysRegData,
  output logic         InHandler,
  output logic         Halted
);

  localparam logic [1:0] RUN     = 2'd0;
  localparam logic [1:0] HANDLER = 2'd1;
  localparam logic [1:0] HALT    = 2'd2;

  logic [1:0]   state;
  logic [1:0]   stateNext;
  logic         irqMeta;
  logic         irqS;
  logic         ackPend;
  logic [N-1:0] elr;
  logic [3:0]   esr;
  logic [31:0]  err;
  logic         irqAck;
  logic         inRun;
  logic         inHandler;
  logic         enterExc;
  logic         isIrq;
  logic         doubleFault;
  logic         leaveHandler;

  assign inRun        = (state == RUN);
  assign inHandler    = (state == HANDLER);
  assign isIrq        = (EStatus == 4'b0001);
  assign enterExc     = inRun & Exc;
  // A fault inside the handler beats a simultaneous ERET.
  assign doubleFault  = inHandler & Exc & (EStatus == 4'b0010);
  assign leaveHandler = inHandler & ERet & ~doubleFault;

  assign EProc     = enterExc;
  assign ERetSel   = leaveHandler;
  assign ExtIRQ    = irqS & inRun & ~ackPend;
  assign IrqAck    = irqAck;
  assign Vector    = VECTOR;
  assign ELR       = elr;
  assign InHandler = inHandler;
  assign Halted    = (state == HALT);

  always_comb begin
    stateNext = state;
    case (state)
      RUN: if (enterExc) stateNext = HANDLER;
      HANDLER: begin
        if (doubleFault)       stateNext = HALT;
        else if (leaveHandler) stateNext = RUN;
      end
      HALT:    stateNext = HALT;
      default: stateNext = RUN;
    endcase
  end

  always_comb begin
    SysRegData = '0;
    case (SysSel)
      2'b00:   SysRegData = elr;
      2'b01:   SysRegData = {{(N-4){1'b0}}, esr};
      2'b10:   SysRegData = {{(N-32){1'b0}}, err};
      default: SysRegData = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= RUN;
      irqMeta <= 1'b0;
      irqS    <= 1'b0;
    end else begin
      state   <= stateNext;
      irqMeta <= IrqReq;
      irqS    <= irqMeta;
    end
  end

  // ackPend hides the synchroniser lag after the device drops its request.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ackPend <= 1'b0;
      irqAck  <= 1'b0;
    end else begin
      irqAck <= enterExc & isIrq;
      if (enterExc && isIrq) ackPend <= 1'b1;
      else if (!irqS)        ackPend <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      elr <= '0;
      esr <= '0;
      err <= '0;
    end else if (enterExc) begin
      elr <= PC_cur;
      esr <= EStatus;
      err <= Instr;
    end
  end

endmodule
